// File: rtl/store_buffer_if.sv
// Request/forward/drain signals of the store buffer, grouped for port use.
// master = requester plus d-cache side; slave = the store buffer itself.
interface store_buffer_if #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
);
  logic                    in_valid;
  logic                    in_is_store;
  logic [ADDR_WIDTH-1:0]   in_addr;
  logic [DATA_WIDTH-1:0]   in_data;
  logic                    in_ready;
  logic                    fwd_hit;
  logic [DATA_WIDTH-1:0]   fwd_data;
  logic                    wr_valid;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    wr_ready;
  logic                    empty;
  logic [$clog2(DEPTH):0]  count;

  modport master (
    output in_valid, in_is_store, in_addr, in_data, wr_ready,
    input  in_ready, fwd_hit, fwd_data, wr_valid, wr_addr, wr_data, empty, count
  );

  modport slave (
    input  in_valid, in_is_store, in_addr, in_data, wr_ready,
    output in_ready, fwd_hit, fwd_data, wr_valid, wr_addr, wr_data, empty, count
  );
endinterface

// File: rtl/store_buffer.sv
// In-order store FIFO with same-cycle youngest-match load forwarding; writes leave from the head register.
// One-cycle enqueue-to-write latency; stores stall (in_ready=0) when full, head holds while !wr_ready.
module store_buffer #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input logic          clk,
  input logic          rst_n,
  store_buffer_if.slave sb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t          ent [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   cnt;

  logic            full;
  logic            enq;
  logic            deq;
  logic            fwd_hit_c;
  logic [DATA_WIDTH-1:0] fwd_data_c;
  logic [PW-1:0]   idx;

  assign full = (cnt == CW'(DEPTH));
  assign enq  = sb.in_valid && sb.in_is_store && !full;
  assign deq  = (cnt != '0) && sb.wr_ready;

  assign sb.in_ready = !full || !sb.in_is_store;
  assign sb.wr_valid = (cnt != '0);
  assign sb.wr_addr  = ent[head].addr;
  assign sb.wr_data  = ent[head].data;
  assign sb.empty    = (cnt == '0);
  assign sb.count    = cnt;
  assign sb.fwd_hit  = fwd_hit_c;
  assign sb.fwd_data = fwd_data_c;

  // Valid entries are contiguous from head, so scanning oldest-to-youngest
  // and letting later matches overwrite leaves the youngest match.
  always_comb begin
    fwd_hit_c  = 1'b0;
    fwd_data_c = '0;
    idx        = '0;
    if (sb.in_valid && !sb.in_is_store) begin
      for (int i = 0; i < DEPTH; i++) begin
        idx = head + PW'(i);
        if (vld[idx] && (ent[idx].addr == sb.in_addr)) begin
          fwd_hit_c  = 1'b1;
          fwd_data_c = ent[idx].data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      ent[tail] <= '{addr: sb.in_addr, data: sb.in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      vld  <= '0;
    end else begin
      // enq and deq never target the same slot: equal pointers imply empty or full.
      if (enq) begin
        vld[tail] <= 1'b1;
        tail      <= tail + PW'(1);
      end
      if (deq) begin
        vld[head] <= 1'b0;
        head      <= head + PW'(1);
      end
      case ({enq, deq})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule
